tron_trail_checker: RTL and testbench
=====================================

# tron_trail_checker

Consumes the stream of player head coordinates produced by the coordinate register, records every visited cell in an internal one-bit-per-cell trail map, and reports a crash when the head enters an already visited cell or leaves the arena. It also drives a single-pixel plot request toward the VGA adapter, so one block both draws the trail and decides the round. After reset it sweeps the whole map clear and paints the arena black before accepting positions.

## Interface

Parameters:
- X_MAX, 160, arena width in cells; legal x is 0..X_MAX-1
- Y_MAX, 120, arena height in cells; legal y is 0..Y_MAX-1
- TRAIL_COLOUR, 3'b010, colour plotted for visited cells

Ports:
- CLOCK_50  in  1  system clock; all state changes on the rising edge
- reset  in  1  reset, synchronous, active-high
- pos_valid  in  1  head position offered
- pos_x  in  8  head x
- pos_y  in  7  head y
- pos_ready  out  1  checker can accept a position this cycle
- step_done  out  1  one-cycle pulse when an accepted position is fully processed
- crash  out  1  sticky; set on the first collision
- crash_x  out  8  x of the colliding position
- crash_y  out  7  y of the colliding position
- plot  out  1  pixel write strobe to the VGA adapter
- plot_x  out  8  pixel x
- plot_y  out  7  pixel y
- plot_colour  out  3  pixel colour

## Operation

- Trail map: X_MAX*Y_MAX one-bit cells with synchronous read, addr = y*X_MAX + x (15 bits for the default parameters, computed without truncation).
- FSM states: CLEAR, IDLE, READ, CHECK, DEAD.
- CLEAR: a counter walks addr 0..X_MAX*Y_MAX-1, writing 0 to one cell per cycle with plot=1, plot_colour=0, and plot_x/plot_y equal to the cell coordinates (x-major within each row). After the last cell, go to IDLE.
- IDLE: pos_ready=1. On pos_valid, latch pos_x/pos_y. If the position is out of range (x>=X_MAX or y>=Y_MAX), or a wall cell under the macro, go to DEAD without any map access. Otherwise go to READ.
- READ: present the latched address to the map.
- CHECK: the map data is valid.
  - If the bit is 1: crash=1, crash_x/crash_y = latched position, step_done=1, go to DEAD.
  - If the bit is 0: write 1, plot=1 at the latched position with TRAIL_COLOUR, step_done=1, return to IDLE.
- DEAD: pos_ready=0, crash held, no plots; left only by reset.
- An out-of-range crash also pulses step_done and latches crash_x/crash_y.
- Positions offered while pos_ready=0 are ignored. The upstream must hold pos_valid until accepted.

## Timing

- Reset values: pos_ready=0, step_done=0, crash=0, crash_x=0, crash_y=0, plot=0, plot_x=0, plot_y=0, plot_colour=0. The state is CLEAR with the counter at 0.
- The first clear plot occurs the cycle after reset deasserts. CLEAR lasts exactly X_MAX*Y_MAX cycles, so pos_ready first rises X_MAX*Y_MAX+1 cycles after reset deasserts.
- In-range step: accepted at edge N. READ at N+1. CHECK at N+2, with step_done and plot (or crash) asserted in that cycle. pos_ready returns at N+3. Throughput is one position per 3 cycles.
- Out-of-range step: crash and step_done are asserted in the cycle after acceptance.
- Reset asserted in any state, including mid-CLEAR or mid-step, aborts the current operation. It restarts CLEAR from addr 0 and clears crash. No partial map write survives the aborted step.
- plot is never asserted in the same cycle as pos_ready.

## Configuration

- TRON_TRAIL_BORDER_EN defined:
  - Cells with x==0, x==X_MAX-1, y==0 or y==Y_MAX-1 are walls; entering one crashes like out-of-range.
  - CLEAR plots wall cells in TRAIL_COLOUR instead of 0.
- TRON_TRAIL_BORDER_EN undefined: only out-of-range positions are walls, and CLEAR plots every cell with colour 0.

## Test plan

- Reset, then wait: exactly 19200 plot pulses with colour 0 (macro off), then pos_ready=1 at cycle 19201.
- Offer (10,20): step_done and plot at (10,20) colour 3'b010 two cycles after acceptance, crash=0. Offer (11,20): same behaviour.
- Revisit (10,20): crash=1, crash_x=10, crash_y=20, no plot, pos_ready stays 0 for the rest of the round.
- Offer (160,5): crash=1 one cycle after acceptance, no map write.
- Macro on, offer (0,50): crash=1. Also check that CLEAR plots (0,0) in 3'b010 and (1,1) in 0.
- Assert reset during CHECK of a fresh cell, then replay (10,20) after the clear: no crash, proving the map was cleared.

Source files
------------

// File: rtl/tron_trail_checker.sv
`timescale 1ns/1ps
// tron_trail_checker: one-bit trail map, collision detection and trail plotting.
// Define TRON_TRAIL_BORDER_EN to turn the arena edge cells into walls.
module tron_trail_checker #(
    parameter int         X_MAX        = 160,
    parameter int         Y_MAX        = 120,
    parameter logic [2:0] TRAIL_COLOUR = 3'b010
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       pos_valid,
    input  logic [7:0] pos_x,
    input  logic [6:0] pos_y,
    output logic       pos_ready,
    output logic       step_done,
    output logic       crash,
    output logic [7:0] crash_x,
    output logic [6:0] crash_y,
    output logic       plot,
    output logic [7:0] plot_x,
    output logic [6:0] plot_y,
    output logic [2:0] plot_colour
);

    localparam int DEPTH = X_MAX * Y_MAX;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [2:0] {CLEAR, IDLE, READ, CHECK, DEAD} state_t;

    state_t     state_q, state_d;
    logic [7:0] clr_x_q, clr_x_d;
    logic [6:0] clr_y_q, clr_y_d;
    logic [7:0] lat_x_q, lat_x_d;
    logic [6:0] lat_y_q, lat_y_d;
    logic       pos_ready_q, pos_ready_d;
    logic       step_q, step_d;
    logic       crash_q, crash_d;
    logic       cp_q, cp_d;
    logic [7:0] cpx_q, cpx_d;
    logic [6:0] cpy_q, cpy_d;
    logic [2:0] cpc_q, cpc_d;

    logic          trail_map [DEPTH];
    logic          map_rdata;
    logic          map_we;
    logic          map_wdata;
    logic [AW-1:0] map_waddr;
    logic [AW-1:0] lat_addr;
    logic          accept;
    logic          hit;
    logic          mark;

    function automatic logic [AW-1:0] addr_of(input logic [7:0] x,
                                              input logic [6:0] y);
        return AW'(int'(y) * X_MAX + int'(x));
    endfunction

`ifdef TRON_TRAIL_BORDER_EN
    function automatic logic is_border(input logic [7:0] x,
                                       input logic [6:0] y);
        return (x == 8'd0) || (int'(x) == X_MAX - 1) ||
               (y == 7'd0) || (int'(y) == Y_MAX - 1);
    endfunction
`endif

    function automatic logic is_wall(input logic [7:0] x,
                                     input logic [6:0] y);
        logic w;
        w = (int'(x) >= X_MAX) || (int'(y) >= Y_MAX);
`ifdef TRON_TRAIL_BORDER_EN
        w = w || is_border(x, y);
`endif
        return w;
    endfunction

    assign lat_addr = addr_of(lat_x_q, lat_y_q);
    assign accept   = pos_ready_q & pos_valid;

    // State register and datapath flops
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= CLEAR;
            clr_x_q     <= '0;
            clr_y_q     <= '0;
            lat_x_q     <= '0;
            lat_y_q     <= '0;
            pos_ready_q <= 1'b0;
            step_q      <= 1'b0;
            crash_q     <= 1'b0;
            cp_q        <= 1'b0;
            cpx_q       <= '0;
            cpy_q       <= '0;
            cpc_q       <= '0;
        end else begin
            state_q     <= state_d;
            clr_x_q     <= clr_x_d;
            clr_y_q     <= clr_y_d;
            lat_x_q     <= lat_x_d;
            lat_y_q     <= lat_y_d;
            pos_ready_q <= pos_ready_d;
            step_q      <= step_d;
            crash_q     <= crash_d;
            cp_q        <= cp_d;
            cpx_q       <= cpx_d;
            cpy_q       <= cpy_d;
            cpc_q       <= cpc_d;
        end
    end

    // Trail map: write blocked under reset so an aborted step leaves no mark
    always_ff @(posedge CLOCK_50) begin
        if (map_we && !reset) begin
            trail_map[map_waddr] <= map_wdata;
        end
        map_rdata <= trail_map[lat_addr];
    end

    // Next state, clear sweep and position latch
    always_comb begin
        state_d   = state_q;
        clr_x_d   = clr_x_q;
        clr_y_d   = clr_y_q;
        lat_x_d   = lat_x_q;
        lat_y_d   = lat_y_q;
        step_d    = 1'b0;
        crash_d   = crash_q;
        cp_d      = 1'b0;
        cpx_d     = '0;
        cpy_d     = '0;
        cpc_d     = '0;
        map_we    = 1'b0;
        map_wdata = 1'b0;
        map_waddr = addr_of(clr_x_q, clr_y_q);
        unique case (state_q)
            CLEAR: begin
                map_we = 1'b1;
                cp_d   = 1'b1;
                cpx_d  = clr_x_q;
                cpy_d  = clr_y_q;
`ifdef TRON_TRAIL_BORDER_EN
                cpc_d  = is_border(clr_x_q, clr_y_q) ? TRAIL_COLOUR : 3'b000;
`endif
                if (int'(clr_x_q) == X_MAX - 1) begin
                    clr_x_d = '0;
                    if (int'(clr_y_q) == Y_MAX - 1) begin
                        clr_y_d = '0;
                        state_d = IDLE;
                    end else begin
                        clr_y_d = clr_y_q + 7'd1;
                    end
                end else begin
                    clr_x_d = clr_x_q + 8'd1;
                end
            end
            IDLE: begin
                if (accept) begin
                    lat_x_d = pos_x;
                    lat_y_d = pos_y;
                    if (is_wall(pos_x, pos_y)) begin
                        crash_d = 1'b1;
                        step_d  = 1'b1;
                        state_d = DEAD;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: state_d = CHECK;
            CHECK: begin
                if (map_rdata) begin
                    crash_d = 1'b1;
                    state_d = DEAD;
                end else begin
                    map_we    = 1'b1;
                    map_wdata = 1'b1;
                    map_waddr = lat_addr;
                    state_d   = IDLE;
                end
            end
            DEAD:    state_d = DEAD;
            default: state_d = CLEAR;
        endcase
        pos_ready_d = (state_d == IDLE) && (state_q != CLEAR);
    end

    // Outputs: CHECK results come straight from the map read data
    always_comb begin
        hit         = (state_q == CHECK) && map_rdata;
        mark        = (state_q == CHECK) && !map_rdata;
        pos_ready   = pos_ready_q;
        step_done   = step_q | (state_q == CHECK);
        crash       = crash_q | hit;
        crash_x     = '0;
        crash_y     = '0;
        if (crash_q || hit) begin
            crash_x = lat_x_q;
            crash_y = lat_y_q;
        end
        plot        = cp_q | mark;
        plot_x      = cpx_q;
        plot_y      = cpy_q;
        plot_colour = cpc_q;
        if (mark) begin
            plot_x      = lat_x_q;
            plot_y      = lat_y_q;
            plot_colour = TRAIL_COLOUR;
        end
    end

endmodule

// File: tb/tb_tron_trail_checker.sv
`timescale 1ns/1ps
// tb_tron_trail_checker: random trail walks against a cell-map reference model.
// Honours TRON_TRAIL_BORDER_EN the same way the design does.
module tb_tron_trail_checker;

    localparam int XM = 160;
    localparam int YM = 120;
    localparam int NCELL = XM * YM;

    logic       CLOCK_50;
    logic       reset;
    logic       pos_valid;
    logic [7:0] pos_x;
    logic [6:0] pos_y;
    logic       pos_ready;
    logic       step_done;
    logic       crash;
    logic [7:0] crash_x;
    logic [6:0] crash_y;
    logic       plot;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_colour;

    int n_chk = 0;
    int n_bad = 0;
    bit vis [XM][YM];
    bit dead_m;

    tron_trail_checker dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .pos_valid  (pos_valid),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_ready  (pos_ready),
        .step_done  (step_done),
        .crash      (crash),
        .crash_x    (crash_x),
        .crash_y    (crash_y),
        .plot       (plot),
        .plot_x     (plot_x),
        .plot_y     (plot_y),
        .plot_colour(plot_colour)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit wall_m(input int x, input int y);
        if (x >= XM || y >= YM) return 1'b1;
`ifdef TRON_TRAIL_BORDER_EN
        if (x == 0 || x == XM - 1 || y == 0 || y == YM - 1) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int clr_colour_m(input int x, input int y);
`ifdef TRON_TRAIL_BORDER_EN
        if (x == 0 || x == XM - 1 || y == 0 || y == YM - 1) return 2;
`endif
        return (x + y) * 0;
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic reset_and_clear();
        int plots;
        int errs;
        int first_rdy;
        int idx;
        reset = 1'b1;
        pos_valid = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_ready", int'(pos_ready), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_step", int'(step_done), 0);
        check("rst_crash", int'(crash), 0);
        check("rst_cx", int'(crash_x), 0);
        check("rst_cy", int'(crash_y), 0);
        check("rst_px", int'(plot_x), 0);
        check("rst_py", int'(plot_y), 0);
        check("rst_pc", int'(plot_colour), 0);
        reset = 1'b0;
        plots = 0;
        errs = 0;
        first_rdy = 0;
        for (int k = 1; k <= NCELL + 5; k++) begin
            tick();
            if (plot) begin
                idx = plots;
                plots++;
                if (int'(plot_x) != idx % XM || int'(plot_y) != idx / XM ||
                    int'(plot_colour) != clr_colour_m(idx % XM, idx / XM))
                    errs++;
            end
            if (k <= NCELL && !plot) errs++;
            if (pos_ready && plot) errs++;
            if (crash || step_done) errs++;
            if (pos_ready) begin
                first_rdy = k;
                break;
            end
        end
        check("clr_plots", plots, NCELL);
        check("clr_errs", errs, 0);
        check("clr_rdy_cycle", first_rdy, NCELL + 1);
        foreach (vis[i, j]) vis[i][j] = 1'b0;
        dead_m = 1'b0;
    endtask

    task automatic do_step(input int x, input int y);
        int xx;
        int yy;
        int w;
        bit hit;
        xx = x & 255;
        yy = y & 127;
        pos_x = xx[7:0];
        pos_y = yy[6:0];
        if (dead_m) begin
            pos_valid = 1'b1;
            repeat (4) begin
                tick();
                check("dead_ready", int'(pos_ready), 0);
                check("dead_plot", int'(plot), 0);
                check("dead_step", int'(step_done), 0);
                check("dead_crash", int'(crash), 1);
            end
            pos_valid = 1'b0;
            return;
        end
        w = 0;
        while (!pos_ready && w < 8) begin
            tick();
            w++;
        end
        check("ready_wait", int'(pos_ready), 1);
        if (!pos_ready) return;
        pos_valid = 1'b1;
        tick();
        pos_valid = 1'b0;
        if (wall_m(xx, yy)) begin
            check("oor_crash", int'(crash), 1);
            check("oor_step", int'(step_done), 1);
            check("oor_cx", int'(crash_x), xx);
            check("oor_cy", int'(crash_y), yy);
            check("oor_plot", int'(plot), 0);
            check("oor_ready", int'(pos_ready), 0);
            dead_m = 1'b1;
            return;
        end
        check("rd_step", int'(step_done), 0);
        check("rd_plot", int'(plot), 0);
        check("rd_ready", int'(pos_ready), 0);
        tick();
        hit = vis[xx][yy];
        check("chk_step", int'(step_done), 1);
        check("chk_ready", int'(pos_ready), 0);
        check("chk_crash", int'(crash), int'(hit));
        check("chk_plot", int'(plot), int'(!hit));
        if (hit) begin
            check("chk_cx", int'(crash_x), xx);
            check("chk_cy", int'(crash_y), yy);
            dead_m = 1'b1;
        end else begin
            check("chk_px", int'(plot_x), xx);
            check("chk_py", int'(plot_y), yy);
            check("chk_pc", int'(plot_colour), 2);
            vis[xx][yy] = 1'b1;
        end
        tick();
        check("post_ready", int'(pos_ready), int'(!dead_m));
        check("post_step", int'(step_done), 0);
        check("post_plot", int'(plot), 0);
        check("post_crash", int'(crash), int'(dead_m));
    endtask

    task automatic abort_in_check(input int x, input int y);
        int w;
        w = 0;
        while (!pos_ready && w < 8) begin
            tick();
            w++;
        end
        check("abort_ready", int'(pos_ready), 1);
        pos_x = x[7:0];
        pos_y = y[6:0];
        pos_valid = 1'b1;
        tick();
        pos_valid = 1'b0;
        tick();
        check("abort_step", int'(step_done), 1);
        check("abort_plot", int'(plot), 1);
        reset = 1'b1;
    endtask

    initial begin
        int hx;
        int hy;
        int nx;
        int ny;
        int r;
        pos_valid = 1'b0;
        pos_x = '0;
        pos_y = '0;
        reset = 1'b1;
        dead_m = 1'b0;

        reset_and_clear();
        do_step(10, 20);
        do_step(11, 20);
        hx = 11;
        hy = 20;
        for (int i = 0; i < 60 && !dead_m; i++) begin
            r = int'($urandom_range(0, 39));
            nx = hx;
            ny = hy;
            if (r == 0) begin
                nx = XM + int'($urandom_range(0, 95));
            end else if (r < 8) begin
                nx = int'($urandom_range(8, 13));
                ny = int'($urandom_range(18, 23));
            end else begin
                unique case ($urandom_range(0, 3))
                    0: nx = hx + 1;
                    1: nx = hx - 1;
                    2: ny = hy + 1;
                    default: ny = hy - 1;
                endcase
            end
            do_step(nx, ny);
            hx = nx;
            hy = ny;
        end
        do_step(10, 20);
        do_step(5, 5);

        reset_and_clear();
        abort_in_check(10, 20);
        reset_and_clear();
        do_step(10, 20);
        do_step(0, 50);
        do_step(160, 5);
        do_step(3, 3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
